dcm_prog_ctrl: RTL

Front-panel controller that selects the slow-clock frequency of the `dcm` clock generator. It debounces two raw push-buttons (up/down) and steps a 3-bit frequency code. For each step it issues a one-cycle `update` with the new `prog_in` to `dcm`, then waits until `dcm` reports the new code on `prog_out`, and flags an error on timeout. It sits between the board buttons and `dcm`, in the 100 MHz `clk` domain.

---
 rtl/dcm_prog_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: debounced up/down buttons step the dcm slow-clock code through an update/acknowledge handshake
// Ports: clk 100 MHz; rst async active-low; btn_up/btn_down raw bouncy buttons; prog_out code reported by dcm;
//   prog_in requested code (registered); update one-cycle load strobe; sel last acknowledged code;
//   busy FSM not idle; err sticky acknowledge timeout.
// Build option: define DCM_PROG_CTRL_WRAP_EN to wrap steps modulo 8 instead of saturating at 0 and 7.
module dcm_prog_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [2:0] prog_out,
  output logic [2:0] prog_in,
  output logic       update,
  output logic [2:0] sel,
  output logic       busy,
  output logic       err
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2;
  logic [1:0] state, sync1, sync2, db, db_q, ev;
  logic [DW-1:0] cnt [2];
  logic [TW-1:0] tcnt;
  logic [2:0] up_code, dn_code, tgt;
  logic go;
  // bit 0 = up, bit 1 = down; counter saturates at DMAX so a held button cannot re-trigger
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db <= '0;
      db_q <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
      db_q <= db;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= !sync2[i] ? '0 : (cnt[i] == DMAX) ? cnt[i] : cnt[i] + 1'b1;
        db[i] <= sync2[i] & (db[i] | (cnt[i] == DMAX));
      end
    end
  assign ev = db & ~db_q;
`ifdef DCM_PROG_CTRL_WRAP_EN
  assign up_code = sel + 3'd1;
  assign dn_code = sel - 3'd1;
`else
  assign up_code = (sel == 3'd7) ? sel : sel + 3'd1;
  assign dn_code = (sel == 3'd0) ? sel : sel - 3'd1;
`endif
  assign tgt = ev[0] ? up_code : dn_code;
  // a lone event whose step actually changes the code; saturated steps yield tgt == sel
  assign go = (ev[0] ^ ev[1]) && (tgt != sel);
  // prog_in is loaded on entry to ISSUE so dcm sees the target together with update,
  // and it holds the target for the whole WAIT_ACK compare.
  // The timeout counter counts WAIT_ACK cycles from 0; expiring at TIMEOUT_CYCLES-2 makes err
  // and the return to IDLE land TIMEOUT_CYCLES cycles after the update cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      prog_in <= '0;
      sel <= '0;
      err <= 1'b0;
      tcnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (go) begin
            state <= ISSUE;
            prog_in <= tgt;
          end
        ISSUE: begin
          state <= WAIT_ACK;
          tcnt <= '0;
        end
        WAIT_ACK:
          if (prog_out == prog_in) begin
            state <= IDLE;
            sel <= prog_in;
            err <= 1'b0;
          end else if (tcnt == TLAST) begin
            state <= IDLE;
            err <= 1'b1;
            prog_in <= sel;
          end else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  assign update = state == ISSUE;
  assign busy = state != IDLE;
endmodule
